// File: rtl/swipt_pkg.sv
// swipt_pkg: shared mode code, framer state type and ADC magnitude fold
package swipt_pkg;
  localparam logic [1:0] PROG_READ = 2'b11;
  typedef enum logic {HUNT, DATA} state_e;
  // Fold an unsigned sample of width w about mid-scale into its distance from the rail.
  function automatic logic [31:0] mag_fold(logic [31:0] s, int unsigned w);
    logic [31:0] half;
    half = 32'd1 << (w - 1);
    return (s < half) ? s : ((half << 1) - 32'd1 - s);
  endfunction
endpackage

// File: rtl/envelope_bit_slicer.sv
// envelope_bit_slicer: per-window peak magnitude tracker and threshold slicer
//   clk, nrst            clock, async active-low reset
//   active_i             block enabled; low clears the window synchronously
//   adc_i, mean_def_i    sample and reference level
//   dec_o, dec_bit_o     combinational decision strobe and bit (for same-edge framing)
//   bit_o, bit_valid_o   registered decided bit and its one-cycle strobe
module envelope_bit_slicer import swipt_pkg::*; #(
  parameter int ADC_W      = 12,
  parameter int BIT_CYCLES = 40000,
  parameter int THRESH_DIV = 15
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             active_i,
  input  logic [ADC_W-1:0] adc_i,
  input  logic [ADC_W-1:0] mean_def_i,
  output logic             dec_o,
  output logic             dec_bit_o,
  output logic             bit_o,
  output logic             bit_valid_o
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(BIT_CYCLES - 1);
  logic [CW-1:0]    cnt_q;
  logic [ADC_W-1:0] peak_q, mag, thr;
  assign mag       = ADC_W'(mag_fold(32'(adc_i), ADC_W));
  assign thr       = mean_def_i - mean_def_i / ADC_W'(THRESH_DIV);
  assign dec_o     = active_i && cnt_q == '0;
  // Low envelope (peak under threshold) reads as a 1.
  assign dec_bit_o = peak_q < thr;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q       <= RELOAD;
      peak_q      <= '0;
      bit_o       <= 1'b0;
      bit_valid_o <= 1'b0;
    end else if (!active_i) begin
      cnt_q       <= RELOAD;
      peak_q      <= '0;
      bit_valid_o <= 1'b0;
    end else if (dec_o) begin
      bit_o       <= dec_bit_o;
      bit_valid_o <= 1'b1;
      peak_q      <= '0;
      cnt_q       <= RELOAD;
    end else begin
      peak_q      <= (mag > peak_q) ? mag : peak_q;
      cnt_q       <= cnt_q - CW'(1);
      bit_valid_o <= 1'b0;
    end
  end
endmodule

// File: rtl/swipt_frame_demod.sv
// swipt_frame_demod: ASK envelope demodulator with sync-hunting word framer
//   clk, nrst                         clock, async active-low reset
//   program_i, readDataIn             block active when program_i==2'b11 and readDataIn
//   ADC, mean_def                     rectified sample and reference level
//   din, bit_valid                    last decided bit and its strobe
//   word, word_valid, word_ready      framed word handshake (MSB first)
//   frame_last, locked, overflow      last-word flag, in-frame flag, sticky drop flag
module swipt_frame_demod import swipt_pkg::*; #(
  parameter int                ADC_W       = 12,
  parameter int                BIT_CYCLES  = 40000,
  parameter int                THRESH_DIV  = 15,
  parameter int                WORD_W      = 8,
  parameter int                SYNC_W      = 8,
  parameter logic [SYNC_W-1:0] SYNC        = 8'hA5,
  parameter int                FRAME_WORDS = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [1:0]        program_i,
  input  logic              readDataIn,
  input  logic [ADC_W-1:0]  ADC,
  input  logic [ADC_W-1:0]  mean_def,
  output logic              din,
  output logic              bit_valid,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_last,
  output logic              locked,
  output logic              overflow
);
  localparam int BW = $clog2(WORD_W + 1);
  localparam int FW = $clog2(FRAME_WORDS + 1);
  localparam int SW = $clog2(SYNC_W + 1);
  logic              active, dec, dec_bit, word_done, frame_done;
  state_e            state_q;
  logic [SYNC_W-1:0] sync_q, sync_d;
  logic [SW-1:0]     sync_cnt_q, sync_cnt_d;
  logic [BW-1:0]     bit_cnt_q;
  logic [FW-1:0]     word_cnt_q;
  logic [WORD_W-1:0] sh_q, sh_d, word_q;
  logic              word_valid_q, frame_last_q, overflow_q;
  assign active = program_i == PROG_READ && readDataIn;
  envelope_bit_slicer #(
    .ADC_W(ADC_W), .BIT_CYCLES(BIT_CYCLES), .THRESH_DIV(THRESH_DIV)
  ) u_slicer (
    .clk(clk), .nrst(nrst), .active_i(active), .adc_i(ADC), .mean_def_i(mean_def),
    .dec_o(dec), .dec_bit_o(dec_bit), .bit_o(din), .bit_valid_o(bit_valid)
  );
  // The framer consumes the bit on the decision edge itself so locked/word_valid
  // line up with the registered bit_valid strobe.
  assign sync_d     = {sync_q[SYNC_W-2:0], dec_bit};
  assign sync_cnt_d = (sync_cnt_q == SW'(SYNC_W)) ? sync_cnt_q : sync_cnt_q + SW'(1);
  assign sh_d       = {sh_q[WORD_W-2:0], dec_bit};
  assign word_done  = dec && state_q == DATA && bit_cnt_q == BW'(WORD_W - 1);
  assign frame_done = word_done && word_cnt_q == FW'(FRAME_WORDS - 1);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= HUNT;
      sync_q       <= '0;
      sync_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      sh_q         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_last_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (!active) begin
      state_q      <= HUNT;
      sync_q       <= '0;
      sync_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      word_valid_q <= 1'b0;
      frame_last_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (word_valid_q && word_ready) begin
        word_valid_q <= 1'b0;
        frame_last_q <= 1'b0;
      end
      if (dec && state_q == HUNT) begin
        sync_q     <= sync_d;
        sync_cnt_q <= sync_cnt_d;
        if (sync_d == SYNC && sync_cnt_d == SW'(SYNC_W)) begin
          state_q    <= DATA;
          bit_cnt_q  <= '0;
          word_cnt_q <= '0;
        end
      end
      if (dec && state_q == DATA) begin
        sh_q      <= sh_d;
        bit_cnt_q <= word_done ? '0 : bit_cnt_q + BW'(1);
        if (word_done) begin
          word_cnt_q <= frame_done ? '0 : word_cnt_q + FW'(1);
          // A word that finds the slot still occupied is dropped; the frame keeps going.
          if (word_valid_q && !word_ready) overflow_q <= 1'b1;
          else begin
            word_q       <= sh_d;
            word_valid_q <= 1'b1;
            frame_last_q <= frame_done;
          end
          if (frame_done) begin
            state_q    <= HUNT;
            sync_q     <= '0;
            sync_cnt_q <= '0;
          end
        end
      end
    end
  end
  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign frame_last = frame_last_q;
  assign locked     = state_q == DATA;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_swipt_frame_demod.sv
// tb_swipt_frame_demod: randomized window-level check of swipt_frame_demod against a behavioural model
module tb_swipt_frame_demod;
  logic        clk = 1'b0, nrst = 1'b0, readDataIn = 1'b1, word_ready = 1'b0;
  logic [1:0]  program_i = 2'b01;
  logic [11:0] ADC = '0, mean_def = 12'h800;
  logic        din, bit_valid, word_valid, frame_last, locked, overflow;
  logic [7:0]  word;
  int          n_chk = 0, n_pass = 0;
  logic        m_din = 0, m_valid = 0, m_last = 0, m_locked = 0, m_ovf = 0;
  logic [7:0]  m_word = '0;
  int          m_nwords = 0;
  logic        hist[$];
  logic        wq[$];

  always #5 clk = ~clk;

  swipt_frame_demod #(.BIT_CYCLES(16)) dut (
    .clk(clk), .nrst(nrst), .program_i(program_i), .readDataIn(readDataIn),
    .ADC(ADC), .mean_def(mean_def), .din(din), .bit_valid(bit_valid),
    .word(word), .word_valid(word_valid), .word_ready(word_ready),
    .frame_last(frame_last), .locked(locked), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int fold(logic [11:0] a);
    return (a < 12'h800) ? int'(a) : 4095 - int'(a);
  endfunction

  // One decided bit through the framing rules; r: 0 ready low, 1 ready whole window, 2 ready on decision cycle only.
  task automatic model_step(input logic b, input int r);
    logic [7:0] pat, nw;
    logic done;
    done = 1'b0;
    m_din = b;
    if (m_valid && r == 1) begin m_valid = 0; m_last = 0; end
    if (!m_locked) begin
      hist.push_back(b);
      if (hist.size() > 8) void'(hist.pop_front());
      pat = '0;
      foreach (hist[i]) pat = {pat[6:0], hist[i]};
      if (hist.size() == 8 && pat == 8'hA5) begin m_locked = 1; wq.delete(); m_nwords = 0; end
    end else begin
      wq.push_back(b);
      if (wq.size() == 8) begin
        nw = '0;
        foreach (wq[i]) nw = {nw[6:0], wq[i]};
        wq.delete();
        m_nwords++;
        done = 1'b1;
        if (m_valid && r == 0) m_ovf = 1;
        else begin m_word = nw; m_valid = 1; m_last = (m_nwords == 4); end
        if (m_nwords == 4) begin m_locked = 0; hist.delete(); m_nwords = 0; end
      end
    end
    if (!done && m_valid && r == 2) begin m_valid = 0; m_last = 0; end
  endtask

  task automatic window(input logic [11:0] s[16], input int r);
    int peak, thr;
    peak = 0;
    thr = int'(mean_def) - int'(mean_def) / 15;
    for (int k = 0; k < 16; k++) begin
      ADC = s[k];
      word_ready = (r == 1) || (r == 2 && k == 15);
      if (k < 15 && fold(s[k]) > peak) peak = fold(s[k]);
      if (k == 8) begin
        chk("bv_mid", 32'(bit_valid), 0);
        chk("wv_mid", 32'(word_valid), 32'(m_valid && r != 1));
        chk("word_mid", 32'(word), 32'(m_word));
      end
      @(negedge clk);
    end
    model_step(peak < thr, r);
    chk("bit_valid", 32'(bit_valid), 1);
    chk("din", 32'(din), 32'(m_din));
    chk("word_valid", 32'(word_valid), 32'(m_valid));
    chk("word", 32'(word), 32'(m_word));
    chk("frame_last", 32'(frame_last), 32'(m_last));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic gen(input logic b, output logic [11:0] s[16]);
    int thr, hi, p, mg;
    thr = int'(mean_def) - int'(mean_def) / 15;
    hi = (thr > 2048) ? 2047 : thr - 1;
    p = int'($urandom_range(14, 0));
    for (int k = 0; k < 16; k++) begin
      mg = b ? int'($urandom_range(hi, 0)) : int'($urandom_range(2047, 0));
      if (!b && k == p && thr <= 2047) mg = int'($urandom_range(2047, thr));
      s[k] = $urandom_range(1, 0) ? 12'(mg) : 12'(4095 - mg);
    end
    s[15] = 12'($urandom_range(4095, 0));
  endtask

  task automatic send_byte(input logic [7:0] v, input int r, input int r_last);
    logic [11:0] s[16];
    int rr;
    for (int i = 7; i >= 0; i--) begin
      gen(v[i], s);
      rr = (i == 0) ? r_last : r;
      if (rr < 0) rr = int'($urandom_range(2, 0));
      window(s, rr);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_last = 0; m_locked = 0; m_ovf = 0; m_nwords = 0;
    hist.delete(); wq.delete();
  endtask

  task automatic abort(input int n);
    logic [11:0] s[16];
    gen(1'b0, s);
    word_ready = 1'b0;
    for (int k = 0; k < n; k++) begin ADC = s[k]; @(negedge clk); end
    readDataIn = 1'b0;
    @(negedge clk);
    chk("ab_wv", 32'(word_valid), 0);
    chk("ab_locked", 32'(locked), 0);
    chk("ab_ovf", 32'(overflow), 0);
    chk("ab_bv", 32'(bit_valid), 0);
    chk("ab_word_hold", 32'(word), 32'(m_word));
    chk("ab_din_hold", 32'(din), 32'(m_din));
    readDataIn = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [11:0] s[16];
    logic [7:0]  data[4];
    int          nbv;
    data = '{8'h3C, 8'hC3, 8'h00, 8'hFF};
    #1;
    chk("rst_outs", 32'({din, bit_valid, word, word_valid, frame_last, locked, overflow}), 0);
    @(negedge clk);
    nrst = 1'b1;
    nbv = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (bit_valid) nbv++; end
    chk("inactive_bv", 32'(nbv), 0);
    program_i = 2'b11;
    s = '{default: 12'h100};
    window(s, 1);
    chk("slice_lo", 32'(din), 1);
    window(s, 1);
    s = '{default: 12'h800};
    window(s, 1);
    chk("slice_hi", 32'(din), 0);
    s = '{default: 12'h100}; s[7] = 12'h778;
    window(s, 1);
    chk("thr_eq", 32'(din), 0);
    s = '{default: 12'h100}; s[7] = 12'h777;
    window(s, 1);
    chk("thr_below", 32'(din), 1);
    s = '{default: 12'h100}; s[3] = 12'h887;
    window(s, 1);
    chk("thr_fold_hi", 32'(din), 0);
    s = '{default: 12'h100}; s[15] = 12'h800;
    window(s, 1);
    chk("dec_sample_ignored", 32'(din), 1);
    abort(5);
    send_byte(8'hA5, 1, 1);
    chk("sync_locked", 32'(locked), 1);
    foreach (data[i]) begin
      send_byte(data[i], 1, 1);
      chk("frm_wv", 32'(word_valid), 1);
      chk("frm_word", 32'(word), 32'(data[i]));
      chk("frm_last", 32'(frame_last), 32'(data[i] == 8'hFF));
      chk("frm_locked", 32'(locked), 32'(data[i] != 8'hFF));
    end
    send_byte(8'hA5, 1, 1);
    send_byte(8'h3C, 0, 0);
    send_byte(8'hC3, 0, 0);
    chk("bp_word", 32'(word), 32'h3C);
    chk("bp_wv", 32'(word_valid), 1);
    chk("bp_ovf", 32'(overflow), 1);
    send_byte(8'h00, 1, 1);
    chk("bp_ovf_sticky", 32'(overflow), 1);
    send_byte(8'hFF, 1, 1);
    abort(3);
    send_byte(8'hA5, 1, 1);
    send_byte(8'h3C, 1, 1);
    send_byte(8'hC3, 0, 2);
    chk("edge_word", 32'(word), 32'hC3);
    chk("edge_wv", 32'(word_valid), 1);
    chk("edge_ovf", 32'(overflow), 0);
    send_byte(8'h00, 1, 1);
    send_byte(8'hFF, 1, 1);
    for (int g = 0; g < 6; g++) begin
      mean_def = 12'($urandom_range(4095, 512));
      send_byte(8'hA5, -1, -1);
      for (int j = 0; j < 4; j++) send_byte(8'($urandom_range(255, 0)), -1, -1);
    end
    mean_def = 12'h800;
    gen(1'b1, s);
    word_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin ADC = s[k]; @(negedge clk); end
    #2 nrst = 1'b0;
    #1 chk("nrst_async_outs", 32'({din, bit_valid, word, word_valid, frame_last, locked, overflow}), 0);
    @(negedge clk);
    nrst = 1'b1;
    model_clear();
    m_din = 0; m_word = '0;
    send_byte(8'hA5, 1, 1);
    send_byte(8'h5A, 1, 1);
    chk("post_rst_word", 32'(word), 32'h5A);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/swipt_frame_demod.md
# swipt_frame_demod

Parametrised successor to the SWIPT envelope bit slicer: demodulates ASK data from the rectified ADC stream into bits, then frames them. Each bit window folds ADC samples about mid-scale and tracks the peak magnitude. The peak is compared with a threshold derived from `mean_def`. Decided bits feed a sync-hunting state machine that assembles fixed-length frames of words, delivered over a valid/ready handshake. Sits between the ADC front end and the program-3 (read) control logic.

## Interface
- `ADC_W`, 12: ADC and `mean_def` width.
- `BIT_CYCLES`, 40000: clock cycles per bit window (≥ 2).
- `THRESH_DIV`, 15: threshold = `mean_def - mean_def/THRESH_DIV`.
- `WORD_W`, 8: data word width.
- `SYNC_W`, 8 / `SYNC`, 8'hA5: sync pattern width and value.
- `FRAME_WORDS`, 4: words per frame after sync.

Ports:
- `clk`  in  1  system clock.
- `nrst`  in  1  reset; asynchronous, active-low.
- `program`  in  2  mode; block active only when 2'b11.
- `readDataIn`  in  1  enable; active high.
- `ADC`  in  ADC_W  unsigned sample.
- `mean_def`  in  ADC_W  reference level.
- `din`  out  1  last decided bit.
- `bit_valid`  out  1  one-cycle strobe per decided bit.
- `word`  out  WORD_W  assembled word, MSB first.
- `word_valid`  out  1  word available.
- `word_ready`  in  1  consumer accepts the word.
- `frame_last`  out  1  qualifies `word` as the last of its frame.
- `locked`  out  1  high while in DATA.
- `overflow`  out  1  sticky: a word was dropped.

## Operation
- Active = `program==2'b11 && readDataIn`. Inactive cycles synchronously clear the following: window counter (reload `BIT_CYCLES-1`), peak, FSM (HUNT), sync/bit/word counters, `bit_valid`, `word_valid`, `frame_last`, `overflow`. `din` and `word` hold.
- Magnitude: `ADC < 2^(ADC_W-1)` → `ADC`, else `2^ADC_W-1 - ADC`.
- Window: counter counts down. When count ≠ 0: `peak <= max(peak, mag)`, decrement. When count = 0: decide, `peak <= 0`, reload. Each window folds `BIT_CYCLES-1` samples. The sample on the decision cycle is discarded.
- Decision: `din <= (peak < thr)`. `thr = mean_def - mean_def/THRESH_DIV` is unsigned, truncating, never underflows. Low envelope reads as 1.
- FSM:
  - HUNT: shift each bit into the sync register (LSB in). Move to DATA when the register equals `SYNC` and at least `SYNC_W` bits have arrived since entering HUNT.
  - DATA: shift bits into the word. After `WORD_W` bits, present the word and increment the word count. After `FRAME_WORDS` words, return to HUNT and clear the sync register and its count.
- Handshake: transfer occurs on an edge with `word_valid && word_ready`. `word`/`frame_last` are stable while valid and unaccepted.
- A word completing while `word_valid` is high and `word_ready` is low: new word dropped, `overflow <= 1`, FSM still advances. If `word_ready` is high on that edge, the old word transfers and the new one loads; `word_valid` stays high.

## Timing
- Reset values: all outputs 0, FSM HUNT, counter `BIT_CYCLES-1`, peak 0.
- First decision: `BIT_CYCLES` cycles after activation. After that, one decision every `BIT_CYCLES` cycles.
- `bit_valid` and updated `din` appear on the edge after the count-0 cycle. `word_valid` rises on the same edge as the `bit_valid` of the word's last bit.
- `locked` rises with the `bit_valid` of the final sync bit. It falls with the `word_valid` of the frame's last word.
- Asynchronous `nrst` mid-window forces reset values immediately. Deactivation takes effect on the next edge.

## Structure
- Package `swipt_pkg`: `PROG_READ = 2'b11`, FSM state enum (HUNT, DATA), shared magnitude-fold function.
- Sub-module `envelope_bit_slicer`: counter, peak tracker, threshold compare. Outputs `bit`/`bit_valid`. The framer/handshake logic is in the top level.

## Test plan
Use `BIT_CYCLES=16` for all scenarios.
- Reset: `nrst` low → all outputs 0. Release, inactive `program=2'b01` → no `bit_valid` for 100 cycles.
- Slicing: `mean_def=0x800` (thr 0x778), ADC constant 0x100 → `din=1`, `bit_valid` every 16 cycles. ADC 0x800 (mag 0x7FF) → `din=0`.
- Threshold boundary: one sample of mag 0x778 in a window → 0. Peak 0x777 → 1. A sample of 0x7FF on the decision cycle only → ignored, `din=1`.
- Framing: bits 0xA5, then 0x3C, 0xC3, 0x00, 0xFF, `word_ready=1` → four `word_valid` pulses with those values. `frame_last` set on 0xFF only. `locked` spans sync completion to the last word.
- Backpressure: `word_ready=0` across two completed words → 0x3C held, `overflow=1`, 0xC3 dropped. Ready on the exact completion edge → 0x3C transfers, 0xC3 presented, no overflow.
- Mid-operation abort: drop `readDataIn` for 1 cycle mid-word → HUNT, `word_valid=0`, next bit after `BIT_CYCLES` cycles. `nrst` low mid-window → outputs 0 without a clock edge.
